pkg_buf_m: RTL and testbench

Frame buffer sitting directly downstream of the 485 fetch stage on the master FPGA. It absorbs the pkg_data/pkg_vld/pkg_frm word stream, stores only complete frames in a circular RAM, and tracks the length of each frame in a small length FIFO. The ARM reads frames out over the fx register bus, which is bridged by the SPI comm block. The block drops frames on overflow, counts the drops, and supports flush and skip via a control register.

---
 rtl/pkg_buf_m.sv | 237 +++++++++++++++++++++++
 tb/tb_pkg_buf_m.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkg_buf_m.sv
// Frame buffer between the 485 fetch stage and the ARM fx register bus: stores whole frames only.
// Optional feature macro PKGBUF_INT_EN adds the pkg_int output and the INT_TH register.
module pkg_buf_m #(
    parameter int         AW     = 10,
    parameter int         LW     = 4,
    parameter logic [5:0] MOD_ID = 6'h23
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic [15:0]   pkg_data,
    input  logic          pkg_vld,
    input  logic          pkg_frm,
    input  logic [21:0]   fx_waddr,
    input  logic          fx_wr,
    input  logic [15:0]   fx_data,
    input  logic [21:0]   fx_raddr,
    input  logic          fx_rd,
    output logic [15:0]   fx_q,
    output logic [LW:0]   frm_cnt
`ifdef PKGBUF_INT_EN
    ,
    output logic          pkg_int
`endif
);

    localparam logic [AW:0] RAM_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [LW:0] LF_FULL  = {1'b1, {LW{1'b0}}};

    logic [15:0] ram     [0:(1<<AW)-1];
    logic [15:0] len_mem [0:(1<<LW)-1];

    logic [AW:0] wr_ptr;
    logic [AW:0] cmt_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] used;
    logic [LW:0] lf_wr;
    logic [LW:0] lf_rd;
    logic [LW:0] lf_cnt;
    logic [15:0] cur_len;
    logic [15:0] head_cons;
    logic [15:0] head_len;
    logic [15:0] head_rem;
    logic [15:0] drop_cnt;
    logic        bad;
    logic        frm_q;

    logic        rd_hit;
    logic        wr_hit;
    logic [15:0] rd_reg;
    logic        flush;
    logic        skip;
    logic        data_rd;
    logic        drop_rd;
    logic        accept;
    logic        full;
    logic        lf_empty;
    logic        lf_full;
    logic        frm_end;
    logic        commit;
    logic        drop;
    logic        ram_we;
    logic        lf_we;

    logic [AW:0] rd_ptr_n;
    logic [LW:0] lf_rd_n;
    logic [15:0] head_cons_n;
    logic [15:0] head_rem_a;
    logic [15:0] rd_mux;

`ifdef PKGBUF_INT_EN
    logic [15:0] int_th;
`endif

    logic unused_bits;
    assign unused_bits = ^{fx_data[15:2], head_rem_a[15:AW+1]};

    assign used     = wr_ptr - rd_ptr;
    assign lf_cnt   = lf_wr - lf_rd;
    assign full     = (used == RAM_FULL);
    assign lf_empty = (lf_cnt == '0);
    assign lf_full  = (lf_cnt == LF_FULL);
    assign head_len = len_mem[lf_rd[LW-1:0]];
    assign head_rem = lf_empty ? 16'h0000 : (head_len - head_cons);

    assign rd_hit  = fx_rd && (fx_raddr[21:16] == MOD_ID);
    assign wr_hit  = fx_wr && (fx_waddr[21:16] == MOD_ID);
    assign rd_reg  = fx_raddr[15:0];
    assign flush   = wr_hit && (fx_waddr[15:0] == 16'h0010) && fx_data[0];
    assign skip    = wr_hit && (fx_waddr[15:0] == 16'h0010) && fx_data[1] && !fx_data[0];
    assign data_rd = rd_hit && (rd_reg == 16'h0002) && !lf_empty;
    assign drop_rd = rd_hit && (rd_reg == 16'h0003);

    // Frame end is detected one cycle after the last word, from the registered envelope.
    assign accept  = pkg_vld && pkg_frm && !bad;
    assign frm_end = frm_q && !pkg_frm;
    assign commit  = frm_end && !flush && !bad && (cur_len != 16'h0000) && !lf_full;
    assign drop    = frm_end && !flush && !commit && (cur_len != 16'h0000);
    assign ram_we  = !rst && !flush && accept && !full;
    assign lf_we   = !rst && commit;

    // Read-side pointer update: a DATA read is applied first, then a SKIP acts on what remains.
    always_comb begin
        rd_ptr_n    = rd_ptr;
        lf_rd_n     = lf_rd;
        head_cons_n = head_cons;
        head_rem_a  = 16'h0000;
        if (data_rd) begin
            rd_ptr_n = rd_ptr + 1'b1;
            if (head_rem == 16'd1) begin
                lf_rd_n     = lf_rd + 1'b1;
                head_cons_n = 16'h0000;
            end else begin
                head_cons_n = head_cons + 1'b1;
            end
        end
        if (lf_wr != lf_rd_n) begin
            head_rem_a = len_mem[lf_rd_n[LW-1:0]] - head_cons_n;
        end
        if (skip && (lf_wr != lf_rd_n)) begin
            rd_ptr_n    = rd_ptr_n + head_rem_a[AW:0];
            lf_rd_n     = lf_rd_n + 1'b1;
            head_cons_n = 16'h0000;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (ram_we) begin
            ram[wr_ptr[AW-1:0]] <= pkg_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (lf_we) begin
            len_mem[lf_wr[LW-1:0]] <= cur_len;
        end
    end

    // A frame already in flight when reset or flush hits is swallowed without counting a drop.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            wr_ptr    <= '0;
            cmt_ptr   <= '0;
            rd_ptr    <= '0;
            lf_wr     <= '0;
            lf_rd     <= '0;
            head_cons <= 16'h0000;
            cur_len   <= 16'h0000;
            bad       <= pkg_frm;
            frm_q     <= pkg_frm;
            frm_cnt   <= '0;
        end else begin
            frm_q <= pkg_frm;
            if (flush) begin
                wr_ptr    <= '0;
                cmt_ptr   <= '0;
                rd_ptr    <= '0;
                lf_wr     <= '0;
                lf_rd     <= '0;
                head_cons <= 16'h0000;
                cur_len   <= 16'h0000;
                bad       <= pkg_frm;
                frm_cnt   <= '0;
            end else begin
                rd_ptr    <= rd_ptr_n;
                lf_rd     <= lf_rd_n;
                head_cons <= head_cons_n;
                if (frm_end) begin
                    cur_len <= 16'h0000;
                    bad     <= 1'b0;
                    if (commit) begin
                        lf_wr   <= lf_wr + 1'b1;
                        cmt_ptr <= wr_ptr;
                    end else begin
                        wr_ptr <= cmt_ptr;
                    end
                end else if (accept) begin
                    if (!full) begin
                        wr_ptr  <= wr_ptr + 1'b1;
                        cur_len <= cur_len + 1'b1;
                    end else begin
                        bad <= 1'b1;
                    end
                end
                frm_cnt <= lf_wr + {{LW{1'b0}}, commit} - lf_rd_n;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            drop_cnt <= 16'h0000;
        end else if (drop_rd) begin
            drop_cnt <= drop ? 16'h0001 : 16'h0000;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    always_comb begin
        rd_mux = 16'h0000;
        if (fx_raddr[21:16] == MOD_ID) begin
            case (rd_reg)
                16'h0000: rd_mux = {drop_cnt != 16'h0000, frm_q, 14'(frm_cnt)};
                16'h0001: rd_mux = head_rem;
                16'h0002: rd_mux = data_rd ? ram[rd_ptr[AW-1:0]] : 16'h0000;
                16'h0003: rd_mux = drop_cnt;
`ifdef PKGBUF_INT_EN
                16'h0011: rd_mux = int_th;
`endif
                default:  rd_mux = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            fx_q <= 16'h0000;
        end else if (fx_rd) begin
            fx_q <= rd_mux;
        end
    end

`ifdef PKGBUF_INT_EN
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            int_th  <= 16'h0001;
            pkg_int <= 1'b0;
        end else begin
            if (wr_hit && (fx_waddr[15:0] == 16'h0011)) begin
                int_th <= fx_data;
            end
            pkg_int <= (int_th != 16'h0000) && (16'(frm_cnt) >= int_th);
        end
    end
`endif

endmodule

// File: tb/tb_pkg_buf_m.sv
// Self-checking bench for pkg_buf_m (AW=4, LW=2) with a frame-level scoreboard model.
module tb_pkg_buf_m;

    localparam int         AW  = 4;
    localparam int         LW  = 2;
    localparam logic [5:0] MID = 6'h23;
    localparam int         DEPTH  = 1 << AW;
    localparam int         NFRAME = 1 << LW;

    logic          clk_sys = 1'b0;
    logic          rst;
    logic [15:0]   pkg_data;
    logic          pkg_vld;
    logic          pkg_frm;
    logic [21:0]   fx_waddr;
    logic          fx_wr;
    logic [15:0]   fx_data;
    logic [21:0]   fx_raddr;
    logic          fx_rd;
    logic [15:0]   fx_q;
    logic [LW:0]   frm_cnt;
`ifdef PKGBUF_INT_EN
    logic          pkg_int;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int exp_drops = 0;
    logic [15:0] exp_words[$];
    int          exp_lens[$];
    logic [15:0] rdq;
    logic [15:0] e;

    pkg_buf_m #(.AW(AW), .LW(LW), .MOD_ID(MID)) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .pkg_data(pkg_data),
        .pkg_vld (pkg_vld),
        .pkg_frm (pkg_frm),
        .fx_waddr(fx_waddr),
        .fx_wr   (fx_wr),
        .fx_data (fx_data),
        .fx_raddr(fx_raddr),
        .fx_rd   (fx_rd),
        .fx_q    (fx_q),
        .frm_cnt (frm_cnt)
`ifdef PKGBUF_INT_EN
        ,
        .pkg_int (pkg_int)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", tag, act, expv);
        end
    endtask

    // All bus tasks start and end just after a falling edge.
    task automatic readReg(input logic [15:0] addr, input logic [5:0] mid, output logic [15:0] q);
        fx_raddr = {mid, addr};
        fx_rd    = 1'b1;
        @(negedge clk_sys);
        fx_rd = 1'b0;
        q     = fx_q;
    endtask

    task automatic writeReg(input logic [15:0] addr, input logic [15:0] data);
        fx_waddr = {MID, addr};
        fx_data  = data;
        fx_wr    = 1'b1;
        @(negedge clk_sys);
        fx_wr = 1'b0;
    endtask

    task automatic applyStimulus(input int len, input logic [15:0] base);
        bit fits;
        fits = (len > 0) && (exp_lens.size() < NFRAME) && (exp_words.size() + len <= DEPTH);
        for (int i = 0; i < len; i++) begin
            pkg_frm  = 1'b1;
            pkg_vld  = 1'b1;
            pkg_data = base + 16'(i);
            @(negedge clk_sys);
        end
        pkg_frm = 1'b0;
        pkg_vld = 1'b0;
        @(negedge clk_sys);
        if (fits) begin
            for (int i = 0; i < len; i++) exp_words.push_back(base + 16'(i));
            exp_lens.push_back(len);
        end else if (len > 0) begin
            exp_drops++;
        end
    endtask

    task automatic modelPop();
        e = exp_words.pop_front();
        exp_lens[0] = exp_lens[0] - 1;
        if (exp_lens[0] == 0) void'(exp_lens.pop_front());
    endtask

    task automatic readData(input string tag);
        readReg(16'h0002, MID, rdq);
        e = 16'h0000;
        if (exp_words.size() > 0) modelPop();
        checkOutput(tag, rdq, e);
    endtask

    task automatic checkModel(input string tag);
        logic [15:0] h;
        h = (exp_lens.size() > 0) ? 16'(exp_lens[0]) : 16'h0000;
        readReg(16'h0001, MID, rdq);
        checkOutput({tag, "_head"}, rdq, h);
        checkOutput({tag, "_cnt"}, 16'(frm_cnt), 16'(exp_lens.size()));
    endtask

    task automatic readDrop(input string tag);
        readReg(16'h0003, MID, rdq);
        checkOutput(tag, rdq, 16'(exp_drops));
        exp_drops = 0;
    endtask

    initial begin
        rst = 1'b1; pkg_data = '0; pkg_vld = 1'b0; pkg_frm = 1'b0;
        fx_waddr = '0; fx_wr = 1'b0; fx_data = '0; fx_raddr = '0; fx_rd = 1'b0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        rst = 1'b0;

        checkOutput("rst_fxq", fx_q, 16'h0000);
        checkOutput("rst_cnt", 16'(frm_cnt), 16'h0000);
        readReg(16'h0000, MID, rdq);
        checkOutput("rst_status", rdq, 16'h0000);
        readData("rst_data_empty");
        checkModel("rst");
        readReg(16'h0011, MID, rdq);
`ifdef PKGBUF_INT_EN
        checkOutput("rst_int_th", rdq, 16'h0001);
`else
        checkOutput("unmapped_0011", rdq, 16'h0000);
`endif

        // Single 5-word frame
        applyStimulus(5, 16'h0001);
        checkModel("f5");
        readReg(16'h0000, MID, rdq);
        checkOutput("f5_status", rdq, 16'h0001);
        readReg(16'h0001, 6'h22, rdq);
        checkOutput("wrong_mod_id", rdq, 16'h0000);
        for (int i = 0; i < 5; i++) readData("f5_data");
        checkModel("f5_done");

        // Overflow frame, then an exactly-full frame
        applyStimulus(20, 16'h0100);
        checkModel("ovf");
        readReg(16'h0000, MID, rdq);
        checkOutput("ovf_status", rdq, 16'h8000);
        readDrop("ovf_drop1");
        readDrop("ovf_drop2");
        applyStimulus(DEPTH, 16'h0200);
        checkModel("full16");
        for (int i = 0; i < DEPTH; i++) readData("full16_data");

        // Three back-to-back frames with a read on the third commit cycle
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 3; i++) exp_words.push_back(16'h0301 + 16'(16 * f + i));
            exp_lens.push_back(3);
        end
        for (int c = 0; c < 12; c++) begin
            if ((c % 4) < 3) begin
                pkg_frm  = 1'b1;
                pkg_vld  = 1'b1;
                pkg_data = 16'h0301 + 16'(16 * (c / 4) + (c % 4));
            end else begin
                pkg_frm = 1'b0;
                pkg_vld = 1'b0;
            end
            if (c == 11) begin
                fx_raddr = {MID, 16'h0002};
                fx_rd    = 1'b1;
                checkOutput("b2b_cnt_before", 16'(frm_cnt), 16'h0002);
            end
            @(negedge clk_sys);
        end
        fx_rd = 1'b0;
        rdq = fx_q;
        modelPop();
        checkOutput("b2b_concurrent_data", rdq, e);
        checkModel("b2b_after");
        for (int i = 0; i < 8; i++) readData("b2b_data");

        // Length FIFO overflow
        for (int f = 0; f < 5; f++) applyStimulus(2, 16'h0401 + 16'(16 * f));
        checkModel("lf_full");
        readReg(16'h0000, MID, rdq);
        checkOutput("lf_full_status", rdq, 16'h8004);
        readDrop("lf_full_drop");
        for (int i = 0; i < 8; i++) readData("lf_full_data");

        // Mid-frame flush
        applyStimulus(3, 16'h0501);
        for (int c = 0; c < 6; c++) begin
            pkg_frm = (c < 5);
            pkg_vld = (c < 5) && (c != 2);
            pkg_data = 16'h0601 + 16'(c);
            fx_wr = 1'b0;
            if (c == 2) begin
                fx_waddr = {MID, 16'h0010};
                fx_data  = 16'h0001;
                fx_wr    = 1'b1;
            end
            @(negedge clk_sys);
        end
        fx_wr = 1'b0;
        @(negedge clk_sys);
        exp_words.delete();
        exp_lens.delete();
        checkModel("flush");
        readDrop("flush_drop");
        applyStimulus(3, 16'h0701);
        for (int i = 0; i < 3; i++) readData("post_flush_data");
        readData("post_flush_empty");

        // Skip
        applyStimulus(4, 16'h0801);
        applyStimulus(3, 16'h0901);
        checkModel("skip_pre");
        readData("skip_first");
        writeReg(16'h0010, 16'h0002);
        repeat (exp_lens[0]) void'(exp_words.pop_front());
        void'(exp_lens.pop_front());
        checkModel("skip_post");
        for (int i = 0; i < 3; i++) readData("skip_data");
        writeReg(16'h0010, 16'h0002);
        checkModel("skip_empty");
        applyStimulus(2, 16'h0A01);
        for (int i = 0; i < 2; i++) readData("skip_empty_data");

`ifdef PKGBUF_INT_EN
        writeReg(16'h0011, 16'h0002);
        readReg(16'h0011, MID, rdq);
        checkOutput("int_th", rdq, 16'h0002);
        applyStimulus(1, 16'h0B01);
        checkOutput("int_one", {15'h0, pkg_int}, 16'h0000);
        applyStimulus(1, 16'h0B02);
        checkOutput("int_commit_cycle", {15'h0, pkg_int}, 16'h0000);
        @(negedge clk_sys);
        checkOutput("int_asserted", {15'h0, pkg_int}, 16'h0001);
        for (int i = 0; i < 2; i++) readData("int_data");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
